// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Multi-cycle MIPS fetch stage. Owns PC and IR, issues one
//            instruction-memory read per fetch, tracks branch/jump redirects.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_busy
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]  r_state,       w_state_nxt;
    logic [31:0] r_next_pc,     w_next_pc_nxt;
    logic        r_redir_pend,  w_redir_pend_nxt;
    logic        r_ireq_valid,  w_ireq_valid_nxt;
    logic [31:0] r_ireq_addr,   w_ireq_addr_nxt;
    logic [31:0] r_instruction, w_instruction_nxt;
    logic [31:0] r_pc,          w_pc_nxt;

    logic [31:0] w_redir_tgt;
    logic [31:0] w_addr_plus4;

    assign w_redir_tgt  = redirect_pc & ~32'd3;
    assign w_addr_plus4 = r_ireq_addr + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_next_pc     <= RESET_PC;
            r_redir_pend  <= 1'b0;
            r_ireq_valid  <= 1'b0;
            r_ireq_addr   <= RESET_PC;
            r_instruction <= 32'd0;
            r_pc          <= RESET_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_next_pc     <= w_next_pc_nxt;
            r_redir_pend  <= w_redir_pend_nxt;
            r_ireq_valid  <= w_ireq_valid_nxt;
            r_ireq_addr   <= w_ireq_addr_nxt;
            r_instruction <= w_instruction_nxt;
            r_pc          <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_next_pc_nxt     = r_next_pc;
        w_redir_pend_nxt  = r_redir_pend;
        w_ireq_valid_nxt  = r_ireq_valid;
        w_ireq_addr_nxt   = r_ireq_addr;
        w_instruction_nxt = r_instruction;
        w_pc_nxt          = r_pc;

        case (r_state)
            c_IDLE: begin
                if (redirect_valid) begin
                    w_next_pc_nxt = w_redir_tgt;
                end
                if (fetch_enable) begin
                    // A same-cycle redirect steers the request being issued.
                    w_ireq_valid_nxt  = 1'b1;
                    w_ireq_addr_nxt   = redirect_valid ? w_redir_tgt : r_next_pc;
                    w_instruction_nxt = 32'd0;
                    w_state_nxt       = c_WAIT;
                end
            end
            c_WAIT: begin
                if (iresp_valid) begin
                    w_instruction_nxt = iresp_data;
                    w_pc_nxt          = r_ireq_addr;
                    w_ireq_valid_nxt  = 1'b0;
                    w_state_nxt       = c_IDLE;
                    w_redir_pend_nxt  = 1'b0;
                    if (redirect_valid) begin
                        w_next_pc_nxt = w_redir_tgt;
                    end else if (!r_redir_pend) begin
                        w_next_pc_nxt = w_addr_plus4;
                    end
                end else if (redirect_valid) begin
                    // Latest redirect wins; the in-flight word still lands in IR.
                    w_next_pc_nxt    = w_redir_tgt;
                    w_redir_pend_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign ireq_valid  = r_ireq_valid;
    assign ireq_addr   = r_ireq_addr;
    assign instruction = r_instruction;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign fetch_busy  = (r_state == c_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_busy;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_enable   (fetch_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .instruction    (instruction),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .fetch_busy     (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        iresp_valid = 1'b0; iresp_data = 32'd0;
        reset = 1'b1;
        #3;
        n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL rst_ireq_valid: got %b want 0", ireq_valid); end
        n_vec++; if (ireq_addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL rst_ireq_addr: got %h want bfc00000", ireq_addr); end
        n_vec++; if (instruction !== 32'd0) begin n_err++; $display("FAIL rst_instruction: got %h want 00000000", instruction); end
        n_vec++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL rst_pc: got %h want bfc00000", pc); end
        n_vec++; if (pc_plus4 !== 32'hBFC0_0004) begin n_err++; $display("FAIL rst_pc_plus4: got %h want bfc00004", pc_plus4); end
        n_vec++; if (fetch_busy !== 1'b0) begin n_err++; $display("FAIL rst_fetch_busy: got %b want 0", fetch_busy); end
        tick();
        reset = 1'b0;
        tick();
        n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_hold: got %b want 0", ireq_valid); end
    endtask

    task automatic test_single_fetch();
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0000 || fetch_busy !== 1'b1) begin
                n_err++; $display("FAIL single_req_cycle%0d: got valid=%b addr=%h busy=%b want 1 bfc00000 1", c, ireq_valid, ireq_addr, fetch_busy);
            end
            if (c == 3) begin iresp_valid = 1'b1; iresp_data = 32'h2008_0005; end
            else tick();
        end
        tick();
        iresp_valid = 1'b0;
        n_vec++; if (instruction !== 32'h2008_0005) begin n_err++; $display("FAIL single_instruction: got %h want 20080005", instruction); end
        n_vec++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL single_pc: got %h want bfc00000", pc); end
        n_vec++; if (pc_plus4 !== 32'hBFC0_0004) begin n_err++; $display("FAIL single_pc_plus4: got %h want bfc00004", pc_plus4); end
        n_vec++; if (ireq_valid !== 1'b0 || fetch_busy !== 1'b0) begin n_err++; $display("FAIL single_done: got valid=%b busy=%b want 0 0", ireq_valid, fetch_busy); end
    endtask

    task automatic test_back_to_back();
        fetch_enable = 1'b1;
        tick();
        n_vec++; if (ireq_addr !== 32'hBFC0_0004 || ireq_valid !== 1'b1) begin n_err++; $display("FAIL b2b_addr2: got valid=%b addr=%h want 1 bfc00004", ireq_valid, ireq_addr); end
        n_vec++; if (instruction !== 32'd0) begin n_err++; $display("FAIL b2b_ir_cleared: got %h want 00000000", instruction); end
        iresp_valid = 1'b1; iresp_data = 32'h8C09_0004;
        tick();
        iresp_valid = 1'b0;
        n_vec++; if (instruction !== 32'h8C09_0004 || pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL b2b_resp2: got ir=%h pc=%h want 8c090004 bfc00004", instruction, pc); end
        n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL b2b_fe_ignored_in_wait: got %b want 0", ireq_valid); end
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_addr !== 32'hBFC0_0008 || ireq_valid !== 1'b1) begin n_err++; $display("FAIL b2b_addr3: got valid=%b addr=%h want 1 bfc00008", ireq_valid, ireq_addr); end
    endtask

    task automatic test_redirect_wait();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (ireq_addr !== 32'hBFC0_0008 || ireq_valid !== 1'b1) begin n_err++; $display("FAIL rw_addr_held: got valid=%b addr=%h want 1 bfc00008", ireq_valid, ireq_addr); end
        iresp_valid = 1'b1; iresp_data = 32'h1111_1111;
        tick();
        iresp_valid = 1'b0;
        n_vec++; if (instruction !== 32'h1111_1111 || pc !== 32'hBFC0_0008) begin n_err++; $display("FAIL rw_inflight_delivered: got ir=%h pc=%h want 11111111 bfc00008", instruction, pc); end
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_addr !== 32'h0000_0200) begin n_err++; $display("FAIL rw_target: got %h want 00000200", ireq_addr); end
        // Redirect coincident with the response, unaligned target.
        iresp_valid = 1'b1; iresp_data = 32'h2222_2222;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0303;
        tick();
        iresp_valid = 1'b0; redirect_valid = 1'b0;
        n_vec++; if (instruction !== 32'h2222_2222 || pc !== 32'h0000_0200 || pc_plus4 !== 32'h0000_0204) begin
            n_err++; $display("FAIL rw_resp_cycle_ir: got ir=%h pc=%h pc4=%h want 22222222 00000200 00000204", instruction, pc, pc_plus4);
        end
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_addr !== 32'h0000_0300) begin n_err++; $display("FAIL rw_resp_cycle_target: got %h want 00000300", ireq_addr); end
        // Two redirects in one WAIT: the later one wins.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        redirect_pc = 32'h0000_0500;
        tick();
        redirect_valid = 1'b0;
        iresp_valid = 1'b1; iresp_data = 32'h3333_3333;
        tick();
        iresp_valid = 1'b0;
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_addr !== 32'h0000_0500) begin n_err++; $display("FAIL rw_last_wins: got %h want 00000500", ireq_addr); end
        iresp_valid = 1'b1; iresp_data = 32'h4444_4444;
        tick();
        iresp_valid = 1'b0;
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_addr !== 32'h0000_0504) begin n_err++; $display("FAIL rw_pend_cleared: got %h want 00000504", ireq_addr); end
        iresp_valid = 1'b1; iresp_data = 32'h5555_5555;
        tick();
        iresp_valid = 1'b0;
    endtask

    task automatic test_redirect_idle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (pc !== 32'h0000_0504 || instruction !== 32'h5555_5555) begin n_err++; $display("FAIL ri_state_kept: got pc=%h ir=%h want 00000504 55555555", pc, instruction); end
        iresp_valid = 1'b1; iresp_data = 32'hDEAD_BEEF;
        tick();
        iresp_valid = 1'b0;
        n_vec++; if (instruction !== 32'h5555_5555 || fetch_busy !== 1'b0) begin n_err++; $display("FAIL ri_resp_ignored: got ir=%h busy=%b want 55555555 0", instruction, fetch_busy); end
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_addr !== 32'h0000_0100) begin n_err++; $display("FAIL ri_target: got %h want 00000100", ireq_addr); end
        iresp_valid = 1'b1; iresp_data = 32'h6666_6666;
        tick();
        iresp_valid = 1'b0;
    endtask

    task automatic test_zero_word();
        do_reset();
        fetch_enable = 1'b1;
        tick();
        n_vec++; if (ireq_addr !== 32'hBFC0_0000 || ireq_valid !== 1'b1) begin n_err++; $display("FAIL zw_first_addr: got valid=%b addr=%h want 1 bfc00000", ireq_valid, ireq_addr); end
        iresp_valid = 1'b1; iresp_data = 32'd0;
        tick();
        iresp_valid = 1'b0;
        n_vec++; if (instruction !== 32'd0 || fetch_busy !== 1'b0) begin n_err++; $display("FAIL zw_nop_loaded: got ir=%h busy=%b want 00000000 0", instruction, fetch_busy); end
        tick();
        n_vec++; if (ireq_addr !== 32'hBFC0_0004 || ireq_valid !== 1'b1) begin n_err++; $display("FAIL zw_refetch_addr: got valid=%b addr=%h want 1 bfc00004", ireq_valid, ireq_addr); end
        iresp_valid = 1'b1; iresp_data = 32'h3C01_BFC0;
        tick();
        iresp_valid = 1'b0; fetch_enable = 1'b0;
        n_vec++; if (instruction !== 32'h3C01_BFC0 || pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL zw_first_nonzero: got ir=%h pc=%h want 3c01bfc0 bfc00004", instruction, pc); end
    endtask

    task automatic test_reset_mid_wait();
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_valid !== 1'b1) begin n_err++; $display("FAIL rmw_req_up: got %b want 1", ireq_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (ireq_valid !== 1'b0 || instruction !== 32'd0 || pc !== 32'hBFC0_0000) begin
            n_err++; $display("FAIL rmw_async: got valid=%b ir=%h pc=%h want 0 00000000 bfc00000", ireq_valid, instruction, pc);
        end
        tick();
        reset = 1'b0;
        iresp_valid = 1'b1; iresp_data = 32'h7777_7777;
        tick();
        iresp_valid = 1'b0;
        n_vec++; if (instruction !== 32'd0 || ireq_valid !== 1'b0 || pc !== 32'hBFC0_0000) begin
            n_err++; $display("FAIL rmw_late_resp: got ir=%h valid=%b pc=%h want 00000000 0 bfc00000", instruction, ireq_valid, pc);
        end
    endtask

    task automatic test_wrap();
        fetch_enable = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        fetch_enable = 1'b0; redirect_valid = 1'b0;
        n_vec++; if (ireq_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req_addr: got %h want fffffffc", ireq_addr); end
        iresp_valid = 1'b1; iresp_data = 32'hABCD_0001;
        tick();
        iresp_valid = 1'b0;
        n_vec++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin n_err++; $display("FAIL wrap_pc_plus4: got pc=%h pc4=%h want fffffffc 00000000", pc, pc_plus4); end
        fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        n_vec++; if (ireq_addr !== 32'd0) begin n_err++; $display("FAIL wrap_next_pc: got %h want 00000000", ireq_addr); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_idle();
        test_zero_word();
        test_reset_mid_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle fetch stage for the MIPS core: owns the program counter and instruction register, issues one instruction-memory read per fetch, and presents the fetched word to the control FSM. Sits directly upstream of the control FSM. It consumes that FSM's `fetch_enable` strobe and a branch/jump redirect from execute. It produces the `instruction` word that the FSM decodes. A zero `instruction` means "not yet fetched", and the FSM holds in its fetch state until the word is non-zero.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `fetch_enable`, input, 1: from FSM `state_enable.fetch_enable`; request a new fetch.
- `redirect_valid`, input, 1: one-cycle pulse; branch taken or jump.
- `redirect_pc`, input, 32: target address; bits [1:0] are ignored and treated as 00.
- `ireq_valid`, output, 1: registered; instruction-memory read request outstanding.
- `ireq_addr`, output, 32: registered; word-aligned read address, stable while `ireq_valid` is high.
- `iresp_valid`, input, 1: memory returns data this cycle.
- `iresp_data`, input, 32: returned word.
- `instruction`, output, 32: instruction register (IR) feeding the FSM.
- `pc`, output, 32: address of the word in IR.
- `pc_plus4`, output, 32: combinational `pc + 4`, mod 2^32.
- `fetch_busy`, output, 1: high in WAIT.

## Operation
- State registers:
  - `state` ∈ {IDLE, WAIT}.
  - `next_pc`: address of the next fetch.
  - `redir_pend`: a redirect arrived during WAIT.
  - IR and `pc`.
- Reset, asynchronous: `state`=IDLE, `ireq_valid`=0, `ireq_addr`=`RESET_PC`, `next_pc`=`RESET_PC`, `instruction`=0, `pc`=`RESET_PC`, `redir_pend`=0, `fetch_busy`=0, `pc_plus4`=`RESET_PC`+4.
- IDLE with `fetch_enable`=1 at a rising edge:
  - `ireq_valid` is set and `ireq_addr` is set to `next_pc`; the effective `next_pc` is the redirect target if `redirect_valid` is high in the same cycle.
  - `instruction` is cleared to 0.
  - `state` becomes WAIT.
- WAIT:
  - `ireq_valid` and `ireq_addr` are held until `iresp_valid`.
  - `fetch_enable` is ignored.
- WAIT with `iresp_valid`=1 at a rising edge:
  - `instruction`←`iresp_data`, `pc`←`ireq_addr`, `ireq_valid`←0, `state`←IDLE.
  - `next_pc`←`ireq_addr`+4, unless a redirect takes priority: if `redirect_valid` is high this cycle, `next_pc`←`redirect_pc`&~3; else if `redir_pend` is set, `next_pc` keeps its stored target. `redir_pend` is cleared.
- `redirect_valid` in IDLE: `next_pc`←`redirect_pc`&~3 immediately. `pc` and `instruction` are unchanged.
- `redirect_valid` in WAIT without a response that cycle:
  - `next_pc`←target and `redir_pend`←1.
  - The in-flight response is still delivered to IR.
  - A later redirect in the same WAIT overwrites the earlier one (the last one wins).
- `iresp_valid` in IDLE is ignored and has no effect.
- Fetched word equal to 0 (NOP): IR becomes 0 and `next_pc` advances normally. The FSM keeps `fetch_enable` high, so the unit re-fetches at `pc`+4 automatically.
- Arithmetic: all PC math is 32-bit unsigned with wrap, so 32'hFFFF_FFFC + 4 = 0.
- Reset mid-WAIT: the request is abandoned; `ireq_valid` drops asynchronously. A late `iresp_valid` after reset is ignored (IDLE rule).

## Timing
- Request latency: `fetch_enable` sampled high at edge N → `ireq_valid` high in cycle N+1.
- Fetch latency:
  - `iresp_valid` sampled at edge M → `instruction`/`pc` valid from cycle M+1.
  - The minimum is a response in the first cycle of `ireq_valid`, giving IR valid two cycles after the `fetch_enable` edge.
- Back-to-back fetches: `fetch_enable` high at edge M (same edge as the response) is ignored, because the state is WAIT. The next request issues from edge M+1 at the earliest.
- `pc_plus4` tracks `pc` combinationally, with no added cycle.

## Test plan
- Reset with `RESET_PC`=32'hBFC0_0000, then `fetch_enable` pulse, memory answers after 3 cycles with 32'h2008_0005 → `ireq_addr`=BFC0_0000 held 3 cycles; `instruction`=2008_0005, `pc`=BFC0_0000, `pc_plus4`=BFC0_0004.
- Two sequential fetches with 0-latency memory → second `ireq_addr`=BFC0_0004; IR is cleared to 0 during the second WAIT.
- Fetched word 0 with `fetch_enable` held high → unit auto-advances; reads at BFC0_0000, then BFC0_0004; IR shows the first non-zero word.
- `redirect_valid` with `redirect_pc`=32'h0000_0103 in IDLE, then fetch → `ireq_addr`=32'h0000_0100.
- Redirect to 32'h0000_0200 during WAIT at BFC0_0008, then response → IR loaded from BFC0_0008; next `ireq_addr`=0000_0200. Repeat with the redirect in the response cycle: same result.
- Reset asserted mid-WAIT, then `iresp_valid` pulse → `ireq_valid`=0 immediately, `instruction`=0, `pc`=`RESET_PC`; the response is ignored. Separately, a fetch at 32'hFFFF_FFFC → `next_pc` wraps to 0.
